// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider producing one quotient bit per clock.
// Unsigned by default. Defining the macro SIGNED_DIV_EN adds the i_is_signed port and a
// two's-complement mode: magnitudes are divided and the signs are applied on the final edge.
// Results and div_by_zero hold their values until the next division completes.
module seq_divider #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,      // asynchronous, active-low
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
`ifdef SIGNED_DIV_EN
   input  logic             i_is_signed,
`endif
   output logic             o_busy,
   output logic             o_ack,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic             o_div_by_zero
);

   localparam int unsigned      CntW    = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0]  LastCnt = CntW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] One     = WIDTH'(1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           r_state;
   state_e           w_state_nxt;

   // Partial remainder is stored in WIDTH bits: after each restore it is below the divisor.
   // The shifted value used for the compare carries the extra bit.
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dsr;
   logic [CntW-1:0]  r_cnt;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_dz;

   logic             w_dsr_zero;
   logic [WIDTH-1:0] w_dvd_mag;
   logic [WIDTH-1:0] w_dsr_mag;
   logic [WIDTH:0]   w_rem_shift;
   logic             w_ge;
   logic [WIDTH-1:0] w_rem_step;
   logic [WIDTH-1:0] w_quo_step;
   logic [WIDTH-1:0] w_quo_res;
   logic [WIDTH-1:0] w_rem_res;

   assign w_dsr_zero = (i_divisor == '0);

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   assign w_rem_shift = {r_rem, r_quo[WIDTH-1]};
   assign w_ge        = (w_rem_shift >= {1'b0, r_dsr});
   assign w_rem_step  = w_ge ? WIDTH'(w_rem_shift - {1'b0, r_dsr}) : w_rem_shift[WIDTH-1:0];
   assign w_quo_step  = {r_quo[WIDTH-2:0], w_ge};

`ifdef SIGNED_DIV_EN
   logic w_dvd_neg;
   logic w_dsr_neg;
   logic r_neg_q;
   logic r_neg_r;

   assign w_dvd_neg = i_is_signed & i_dividend[WIDTH-1];
   assign w_dsr_neg = i_is_signed & i_divisor[WIDTH-1];
   // Most-negative magnitude still fits as an unsigned WIDTH-bit value.
   assign w_dvd_mag = w_dvd_neg ? (~i_dividend + One) : i_dividend;
   assign w_dsr_mag = w_dsr_neg ? (~i_divisor + One) : i_divisor;
   // Quotient truncates toward zero; remainder follows the dividend's sign.
   assign w_quo_res = r_neg_q ? (~w_quo_step + One) : w_quo_step;
   assign w_rem_res = r_neg_r ? (~w_rem_step + One) : w_rem_step;

   // Capture result signs when a division is launched
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (r_state == StIdle && i_start) begin
         r_neg_q <= w_dvd_neg ^ w_dsr_neg;
         r_neg_r <= w_dvd_neg;
      end
   end
`else
   assign w_dvd_mag = i_dividend;
   assign w_dsr_mag = i_divisor;
   assign w_quo_res = w_quo_step;
   assign w_rem_res = w_rem_step;
`endif

   // State register
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StIdle: begin
            if (i_start) begin
               w_state_nxt = w_dsr_zero ? StDone : StRun;
            end
         end
         StRun: begin
            if (r_cnt == LastCnt) begin
               w_state_nxt = StDone;
            end
         end
         StDone:  w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   // Status outputs decoded from the state register
   always_comb begin
      o_busy = 1'b0;
      o_ack  = 1'b0;
      case (r_state)
         StRun: begin
            o_busy = 1'b1;
         end
         StDone: begin
            o_busy = 1'b1;
            o_ack  = 1'b1;
         end
         default: begin
            o_busy = 1'b0;
            o_ack  = 1'b0;
         end
      endcase
   end

   // Operand capture, iteration and result registers
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_rem       <= '0;
         r_quo       <= '0;
         r_dsr       <= '0;
         r_cnt       <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dz        <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (i_start) begin
                  if (w_dsr_zero) begin
                     r_quotient  <= '1;
                     r_remainder <= i_dividend;
                     r_dz        <= 1'b1;
                  end else begin
                     r_rem <= '0;
                     r_quo <= w_dvd_mag;
                     r_dsr <= w_dsr_mag;
                     r_cnt <= '0;
                  end
               end
            end
            StRun: begin
               r_rem <= w_rem_step;
               r_quo <= w_quo_step;
               r_cnt <= r_cnt + CntW'(1);
               if (r_cnt == LastCnt) begin
                  r_quotient  <= w_quo_res;
                  r_remainder <= w_rem_res;
                  r_dz        <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_quotient    = r_quotient;
   assign o_remainder   = r_remainder;
   assign o_div_by_zero = r_dz;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed table, multi-cycle corner sequences and a
// randomized sweep (WIDTH=8 and WIDTH=16) against an arithmetic reference model.
module tb_seq_divider;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        start8, sgn8, busy8, ack8, dz8;
   logic [7:0]  dvd8, dsr8, quo8, rem8;
   logic        start16, sgn16, busy16, ack16, dz16;
   logic [15:0] dvd16, dsr16, quo16, rem16;

   int          n_pass  = 0;
   int          n_total = 0;

   vec_t        tbl [11];
   logic [7:0]  q8, r8;
   logic [15:0] q16, r16;
   bit          dzo, pulse, edz, saw, bad;
   int          lat;
   longint      eq, er;
   logic [15:0] ra, rb;
   bit          rs;

   always #5 clk = ~clk;

   seq_divider #(.WIDTH(8)) u_dut8 (
      .i_clk         (clk),
      .i_reset       (rst_n),
      .i_start       (start8),
      .i_dividend    (dvd8),
      .i_divisor     (dsr8),
`ifdef SIGNED_DIV_EN
      .i_is_signed   (sgn8),
`endif
      .o_busy        (busy8),
      .o_ack         (ack8),
      .o_quotient    (quo8),
      .o_remainder   (rem8),
      .o_div_by_zero (dz8)
   );

   seq_divider #(.WIDTH(16)) u_dut16 (
      .i_clk         (clk),
      .i_reset       (rst_n),
      .i_start       (start16),
      .i_dividend    (dvd16),
      .i_divisor     (dsr16),
`ifdef SIGNED_DIV_EN
      .i_is_signed   (sgn16),
`endif
      .o_busy        (busy16),
      .o_ack         (ack16),
      .o_quotient    (quo16),
      .o_remainder   (rem16),
      .o_div_by_zero (dz16)
   );

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Reference: plain integer division with the documented zero/sign rules.
   function automatic void ref_div(input int w, input longint a, input longint b, input bit sgn,
                                   output longint q, output longint r, output bit dz);
      longint mask;
      longint sa, sb;
      mask = (longint'(1) << w) - 1;
      dz   = (b == 0);
      if (b == 0) begin
         q = mask;
         r = a;
      end else if (!sgn) begin
         q = a / b;
         r = a % b;
      end else begin
         sa = a[w-1] ? a - (longint'(1) << w) : a;
         sb = b[w-1] ? b - (longint'(1) << w) : b;
         q  = (sa / sb) & mask;
         r  = (sa % sb) & mask;
      end
   endfunction

   // Called #1 after an edge with the DUT idle; returns #1 after the edge following ack.
   task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit sgn,
                       output logic [7:0] q, output logic [7:0] r, output bit dz,
                       output int l, output bit p);
      start8 = 1'b1;
      dvd8   = a;
      dsr8   = b;
      sgn8   = sgn;
      @(posedge clk); #1;
      start8 = 1'b0;
      dvd8   = 8'($urandom);
      dsr8   = 8'($urandom);
      l      = 0;
      while (!ack8 && l < 40) begin
         @(posedge clk); #1;
         l++;
      end
      q  = quo8;
      r  = rem8;
      dz = dz8;
      @(posedge clk); #1;
      p = !ack8 && !busy8;
   endtask

   task automatic run16(input logic [15:0] a, input logic [15:0] b, input bit sgn,
                        output logic [15:0] q, output logic [15:0] r, output bit dz,
                        output int l);
      start16 = 1'b1;
      dvd16   = a;
      dsr16   = b;
      sgn16   = sgn;
      @(posedge clk); #1;
      start16 = 1'b0;
      dvd16   = 16'($urandom);
      dsr16   = 16'($urandom);
      l       = 0;
      while (!ack16 && l < 60) begin
         @(posedge clk); #1;
         l++;
      end
      q  = quo16;
      r  = rem16;
      dz = dz16;
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
      $fatal(1, "watchdog");
   end

   initial begin
      tbl = '{
         '{8'd4,   8'd2,   8'd2,   8'd0,   1'b0},
         '{8'd3,   8'd255, 8'd0,   8'd3,   1'b0},
         '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0},
         '{8'd7,   8'd0,   8'hFF,  8'd7,   1'b1},
         '{8'd200, 8'd9,   8'd22,  8'd2,   1'b0},
         '{8'd13,  8'd13,  8'd1,   8'd0,   1'b0},
         '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0},
         '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0},
         '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0},
         '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1},
         '{8'd1,   8'd3,   8'd0,   8'd1,   1'b0}
      };

      rst_n   = 1'b0;
      start8  = 1'b0; dvd8  = '0; dsr8  = '0; sgn8  = 1'b0;
      start16 = 1'b0; dvd16 = '0; dsr16 = '0; sgn16 = 1'b0;
      #12;
      check("reset_busy", busy8, 0);
      check("reset_ack", ack8, 0);
      check("reset_quotient", quo8, 0);
      check("reset_remainder", rem8, 0);
      check("reset_dz", dz8, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed table, issued back to back (each start one edge after ack falls)
      for (int i = 0; i < 11; i++) begin
         run8(tbl[i].a, tbl[i].b, 1'b0, q8, r8, dzo, lat, pulse);
         check($sformatf("tbl%0d_quotient", i), q8, tbl[i].q);
         check($sformatf("tbl%0d_remainder", i), r8, tbl[i].r);
         check($sformatf("tbl%0d_dz", i), dzo, tbl[i].dz);
         check($sformatf("tbl%0d_latency", i), lat, tbl[i].dz ? 0 : 8);
         check($sformatf("tbl%0d_ack_width", i), pulse, 1);
      end

      // Start while busy is ignored: 200/7 launched, 9/3 pulsed before edge 3
      dvd8 = 8'd200; dsr8 = 8'd7; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      bad = 1'b0;
      saw = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         if (e == 3) begin
            start8 = 1'b1; dvd8 = 8'd9; dsr8 = 8'd3;
         end
         @(posedge clk); #1;
         start8 = 1'b0;
         if (!busy8) bad = 1'b1;
         if (e < 8 && ack8) saw = 1'b1;
      end
      check("busy_edges_1_to_8", bad, 0);
      check("no_early_ack", saw, 0);
      check("ack_at_edge_8", ack8, 1);
      check("ignored_start_quotient", quo8, 28);
      check("ignored_start_remainder", rem8, 4);
      @(posedge clk); #1;
      check("idle_after_done", busy8, 0);

      // Reset during RUN aborts the division
      dvd8 = 8'd100; dsr8 = 8'd9; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_busy", busy8, 0);
      check("abort_ack", ack8, 0);
      check("abort_quotient", quo8, 0);
      check("abort_remainder", rem8, 0);
      check("abort_dz", dz8, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      saw = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (ack8 || busy8) saw = 1'b1;
      end
      check("abort_no_ack", saw, 0);
      run8(8'd100, 8'd9, 1'b0, q8, r8, dzo, lat, pulse);
      check("fresh_quotient", q8, 11);
      check("fresh_remainder", r8, 1);
      check("fresh_latency", lat, 8);

`ifdef SIGNED_DIV_EN
      run8(8'hF9, 8'h02, 1'b1, q8, r8, dzo, lat, pulse);
      check("s_m7_2_quotient", q8, 8'hFD);
      check("s_m7_2_remainder", r8, 8'hFF);
      check("s_m7_2_latency", lat, 8);
      run8(8'h80, 8'hFF, 1'b1, q8, r8, dzo, lat, pulse);
      check("s_ovf_quotient", q8, 8'h80);
      check("s_ovf_remainder", r8, 8'h00);
      check("s_ovf_dz", dzo, 0);
      run8(8'h07, 8'hFE, 1'b1, q8, r8, dzo, lat, pulse);
      check("s_7_m2_quotient", q8, 8'hFD);
      check("s_7_m2_remainder", r8, 8'h01);
      run8(8'h80, 8'h00, 1'b1, q8, r8, dzo, lat, pulse);
      check("s_dz_quotient", q8, 8'hFF);
      check("s_dz_remainder", r8, 8'h80);
      check("s_dz_flag", dzo, 1);
`endif

      // Randomized sweep, WIDTH=8
      for (int i = 0; i < 150; i++) begin
         ra = 16'($urandom_range(0, 255));
         rb = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(0, 255));
`ifdef SIGNED_DIV_EN
         rs = 1'($urandom_range(0, 1));
`else
         rs = 1'b0;
`endif
         ref_div(8, ra, rb, rs, eq, er, edz);
         run8(ra[7:0], rb[7:0], rs, q8, r8, dzo, lat, pulse);
         check($sformatf("rnd8_%0d_q %0h/%0h s%0d", i, ra, rb, rs), q8, eq);
         check($sformatf("rnd8_%0d_r %0h/%0h s%0d", i, ra, rb, rs), r8, er);
         check($sformatf("rnd8_%0d_dz", i), dzo, edz);
         check($sformatf("rnd8_%0d_latency", i), lat, edz ? 0 : 8);
      end

      // Randomized sweep, WIDTH=16
      for (int i = 0; i < 80; i++) begin
         ra = 16'($urandom);
         rb = ($urandom_range(0, 9) == 0) ? 16'd0 :
              (($urandom_range(0, 1) == 0) ? 16'($urandom_range(1, 300)) : 16'($urandom));
`ifdef SIGNED_DIV_EN
         rs = 1'($urandom_range(0, 1));
`else
         rs = 1'b0;
`endif
         ref_div(16, ra, rb, rs, eq, er, edz);
         run16(ra, rb, rs, q16, r16, dzo, lat);
         check($sformatf("rnd16_%0d_q %0h/%0h s%0d", i, ra, rb, rs), q16, eq);
         check($sformatf("rnd16_%0d_r %0h/%0h s%0d", i, ra, rb, rs), r16, er);
         check($sformatf("rnd16_%0d_dz", i), dzo, edz);
         check($sformatf("rnd16_%0d_latency", i), lat, edz ? 0 : 16);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
